// File: rtl/alu_acc_flag_unit.sv
// Accumulator-based ALU with carry/zero/sign/overflow flags.
// The accumulator is the left operand; the right operand comes from a source mux.
module alu_acc_flag_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       data_src,
  input  logic [WIDTH-1:0] immediate,
  input  logic [WIDTH-1:0] reg_out,
  input  logic [WIDTH-1:0] mem_out,
  input  logic [2:0]       op,
  input  logic             ce_a,
  input  logic             ce_cy,
  output logic [WIDTH-1:0] alu_in,
  output logic [WIDTH-1:0] acc_v,
  output logic             flag_cy,
  output logic             flag_z,
  output logic             flag_s,
  output logic             flag_o
);

  localparam logic [1:0] SRC_MEM_ADDR  = 2'd0;
  localparam logic [1:0] SRC_IMMEDIATE = 2'd1;
  localparam logic [1:0] SRC_INDIRECT  = 2'd2;
  localparam logic [1:0] SRC_REG       = 2'd3;

  localparam logic [2:0] OP_LD  = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_ADC = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SBC = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_b;
  logic [WIDTH:0]   ext_c;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res;
  logic             co;
  logic             ov;

  always_comb begin
    alu_in = mem_out;
    case (data_src)
      SRC_MEM_ADDR:  alu_in = mem_out;
      SRC_IMMEDIATE: alu_in = immediate;
      SRC_INDIRECT:  alu_in = mem_out;
      SRC_REG:       alu_in = reg_out;
      default:       alu_in = mem_out;
    endcase
  end

  assign ext_a = {1'b0, acc_v};
  assign ext_b = {1'b0, alu_in};
  assign ext_c = {{WIDTH{1'b0}}, flag_cy};

  // Subtraction in WIDTH+1 bits leaves the borrow in the top bit.
  always_comb begin
    wide = '0;
    res  = '0;
    co   = 1'b0;
    ov   = 1'b0;
    case (op)
      OP_LD: begin
        res = alu_in;
      end
      OP_ADD, OP_ADC: begin
        wide = (op == OP_ADC) ? (ext_a + ext_b + ext_c) : (ext_a + ext_b);
        res  = wide[WIDTH-1:0];
        co   = wide[WIDTH];
        ov   = (acc_v[MSB] == alu_in[MSB]) && (res[MSB] != acc_v[MSB]);
      end
      OP_SUB, OP_SBC: begin
        wide = (op == OP_SBC) ? (ext_a - ext_b - ext_c) : (ext_a - ext_b);
        res  = wide[WIDTH-1:0];
        co   = wide[WIDTH];
        ov   = (acc_v[MSB] != alu_in[MSB]) && (res[MSB] != acc_v[MSB]);
      end
      OP_AND: res = acc_v & alu_in;
      OP_OR:  res = acc_v | alu_in;
      OP_XOR: res = acc_v ^ alu_in;
      default: res = alu_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_v   <= '0;
      flag_cy <= 1'b0;
      flag_z  <= 1'b1;
      flag_s  <= 1'b0;
      flag_o  <= 1'b0;
    end else begin
      if (ce_a) begin
        acc_v  <= res;
        flag_z <= (res == '0);
        flag_s <= res[MSB];
        flag_o <= ov;
      end
      if (ce_cy) begin
        flag_cy <= co;
      end
    end
  end

endmodule

// File: tb/tb_alu_acc_flag_unit.sv
// Bench for alu_acc_flag_unit: directed plan cases plus random traffic
// against an integer-arithmetic reference model.
module tb_alu_acc_flag_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] data_src;
  logic [7:0] immediate;
  logic [7:0] reg_out;
  logic [7:0] mem_out;
  logic [2:0] op;
  logic       ce_a;
  logic       ce_cy;
  logic [7:0] alu_in;
  logic [7:0] acc_v;
  logic       flag_cy;
  logic       flag_z;
  logic       flag_s;
  logic       flag_o;

  int n_cmp = 0;
  int n_err = 0;

  int m_acc = 0;
  int m_cy  = 0;
  int m_z   = 1;
  int m_s   = 0;
  int m_o   = 0;

  always #5 clk = ~clk;

  alu_acc_flag_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .data_src(data_src), .immediate(immediate),
    .reg_out(reg_out), .mem_out(mem_out), .op(op), .ce_a(ce_a), .ce_cy(ce_cy),
    .alu_in(alu_in), .acc_v(acc_v), .flag_cy(flag_cy), .flag_z(flag_z),
    .flag_s(flag_s), .flag_o(flag_o)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: present inputs, check the mux, step the model, check registers.
  task automatic cycle(input logic r, input logic [1:0] src, input logic [7:0] imm,
                       input logic [7:0] rg, input logic [7:0] mem, input logic [2:0] o_,
                       input logic ea, input logic ec);
    int a, b, c, t, res, co, ov;
    @(negedge clk);
    rst = r; data_src = src; immediate = imm; reg_out = rg; mem_out = mem;
    op = o_; ce_a = ea; ce_cy = ec;
    #1;
    if (src == 2'd1)      b = imm;
    else if (src == 2'd3) b = rg;
    else                  b = mem;
    chk("alu_in", int'(alu_in), b);
    a = m_acc; c = m_cy; co = 0; ov = 0; t = 0;
    case (o_)
      3'd0: res = b;
      3'd1, 3'd2: begin
        t   = a + b + ((o_ == 3'd2) ? c : 0);
        res = t % 256;
        co  = (t > 255) ? 1 : 0;
        ov  = ((a >= 128) == (b >= 128) && (res >= 128) != (a >= 128)) ? 1 : 0;
      end
      3'd3, 3'd4: begin
        t   = a - b - ((o_ == 3'd4) ? c : 0);
        res = (t + 512) % 256;
        co  = (t < 0) ? 1 : 0;
        ov  = ((a >= 128) != (b >= 128) && (res >= 128) != (a >= 128)) ? 1 : 0;
      end
      3'd5: res = a & b;
      3'd6: res = a | b;
      default: res = a ^ b;
    endcase
    @(posedge clk);
    #1;
    if (!r) begin
      m_acc = 0; m_cy = 0; m_z = 1; m_s = 0; m_o = 0;
    end else begin
      if (ea) begin
        m_acc = res;
        m_z   = (res == 0) ? 1 : 0;
        m_s   = (res >= 128) ? 1 : 0;
        m_o   = ov;
      end
      if (ec) m_cy = co;
    end
    chk("acc_v",   int'(acc_v),   m_acc);
    chk("flag_cy", int'(flag_cy), m_cy);
    chk("flag_z",  int'(flag_z),  m_z);
    chk("flag_s",  int'(flag_s),  m_s);
    chk("flag_o",  int'(flag_o),  m_o);
  endtask

  task automatic ld_imm(input logic [7:0] v);
    cycle(1'b1, 2'd1, v, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1);
  endtask

  task automatic alu_imm(input logic [2:0] o_, input logic [7:0] v);
    cycle(1'b1, 2'd1, v, 8'h00, 8'h00, o_, 1'b1, 1'b1);
  endtask

  // Absolute values from the plan, independent of the model.
  task automatic plan(input string tag, input int acc, input int cy, input int z,
                      input int s, input int o);
    chk({tag, ".acc"}, int'(acc_v), acc);
    if (cy >= 0) chk({tag, ".cy"}, int'(flag_cy), cy);
    if (z  >= 0) chk({tag, ".z"},  int'(flag_z),  z);
    if (s  >= 0) chk({tag, ".s"},  int'(flag_s),  s);
    if (o  >= 0) chk({tag, ".o"},  int'(flag_o),  o);
  endtask

  initial begin
    rst = 1'b0; data_src = 2'd0; immediate = '0; reg_out = '0; mem_out = '0;
    op = 3'd1; ce_a = 1'b1; ce_cy = 1'b1;

    repeat (2) cycle(1'b0, 2'd1, 8'h5A, 8'h00, 8'h00, 3'd1, 1'b1, 1'b1);
    plan("reset", 8'h00, 0, 1, 0, 0);

    for (int i = 0; i < 4; i++)
      cycle(1'b1, 2'(i), 8'h22, 8'h33, 8'h11, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 8'h22, 8'h33, 8'h11, 3'd0, 1'b1, 1'b0);
    plan("ld_reg", 8'h33, -1, 0, 0, 0);

    ld_imm(8'hFF); alu_imm(3'd1, 8'h01); plan("add_wrap", 8'h00, 1, 1, 0, 0);
    alu_imm(3'd2, 8'h00);                plan("adc",      8'h01, 0, 0, -1, -1);
    ld_imm(8'h7F); alu_imm(3'd1, 8'h01); plan("add_ovf",  8'h80, -1, -1, 1, 1);

    ld_imm(8'h00); alu_imm(3'd3, 8'h01); plan("sub_brw",  8'hFF, 1, -1, 1, -1);
    alu_imm(3'd4, 8'h00);                plan("sbc",      8'hFE, 0, -1, -1, -1);
    ld_imm(8'h80); alu_imm(3'd3, 8'h01); plan("sub_ovf",  8'h7F, -1, -1, -1, 1);

    ld_imm(8'hF0); alu_imm(3'd5, 8'h3C); plan("and", 8'h30, 0, 0, -1, 0);
    ld_imm(8'hF0); alu_imm(3'd6, 8'h3C); plan("or",  8'hFC, 0, 0, -1, 0);
    ld_imm(8'hF0); alu_imm(3'd7, 8'h3C); plan("xor", 8'hCC, 0, 0, -1, 0);
    ld_imm(8'hF0); alu_imm(3'd5, 8'h0F); plan("and_z", 8'h00, 0, 1, 0, 0);

    ld_imm(8'hFF);
    cycle(1'b1, 2'd1, 8'h01, 8'h00, 8'h00, 3'd1, 1'b0, 1'b1);
    plan("ce_cy_only", 8'hFF, 1, 0, 1, 0);
    cycle(1'b1, 2'd1, 8'h05, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
    plan("ce_a_only", 8'h05, 1, 0, 0, 0);

    cycle(1'b0, 2'd1, 8'h10, 8'h00, 8'h00, 3'd1, 1'b1, 1'b1);
    plan("mid_reset", 8'h00, 0, 1, 0, 0);

    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(31) != 0), 2'($urandom_range(3)), 8'($urandom),
            8'($urandom), 8'($urandom), 3'($urandom_range(7)),
            ($urandom_range(3) != 0), ($urandom_range(3) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_acc_flag_unit.md
Name: alu_acc_flag_unit

Overview:
8-bit ALU with an accumulator register and four status flags (carry, zero, sign, overflow), used in the CPU datapath. A 2-bit source select picks the right-hand operand from immediate, register-file or memory data. The accumulator is the left-hand operand. Accumulator and flags update on the rising clock edge under separate clock enables.

Parameters:
WIDTH, 8, datapath width of the accumulator, operands and result (the flag semantics below assume WIDTH-1 is the sign bit).

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset; synchronous, active-low (0 = reset)
data_src  input  2  operand select: 0 SRC_MEM_ADDR, 1 SRC_IMMEDIATE, 2 SRC_INDIRECT, 3 SRC_REG
immediate  input  WIDTH  immediate operand from the instruction
reg_out  input  WIDTH  register-file read data
mem_out  input  WIDTH  memory read data (direct or indirect access)
op  input  3  ALU operation code
ce_a  input  1  enable for the accumulator and the z/s/o flags
ce_cy  input  1  enable for the carry flag
alu_in  output  WIDTH  selected right-hand operand (combinational)
acc_v  output  WIDTH  accumulator value (registered)
flag_cy  output  1  carry/borrow flag (registered)
flag_z  output  1  zero flag (registered)
flag_s  output  1  sign flag (registered)
flag_o  output  1  signed overflow flag (registered)

Behaviour:
- Operand mux (combinational): alu_in = mem_out for data_src 0 or 2; immediate for 1; reg_out for 3.
- Let A = acc_v, B = alu_in, C = flag_cy. The result R (WIDTH bits) and carry-out co are computed combinationally:
  - op 0 LD: R = B; co = 0.
  - op 1 ADD: {co,R} = A + B.
  - op 2 ADC: {co,R} = A + B + C.
  - op 3 SUB: R = A - B; co = borrow (1 when A < B unsigned).
  - op 4 SBC: R = A - B - C; co = borrow (1 when A < B + C unsigned).
  - op 5 AND: R = A & B; co = 0.
  - op 6 OR: R = A | B; co = 0.
  - op 7 XOR: R = A ^ B; co = 0.
- Overflow o:
  - ADD/ADC: operands have the same sign and R's sign differs from A.
  - SUB/SBC: A and B signs differ and R's sign differs from A.
  - All other ops: 0.
- Clock edge, rst = 0: acc_v = 0, flag_cy = 0, flag_z = 1, flag_s = 0, flag_o = 0. Reset overrides ce_a and ce_cy.
- Clock edge, rst = 1:
  - if ce_a: acc_v <= R; flag_z <= (R == 0); flag_s <= R[WIDTH-1]; flag_o <= o.
  - if ce_cy: flag_cy <= co.
  - A disabled register holds its value. ce_a and ce_cy are independent.
- Latency: result and flags are visible one clock after op, data_src and operands are presented. alu_in has zero latency.
- ADC/SBC use flag_cy as registered before the edge.
- All outputs come directly from registers, except alu_in.
- Wrap-around is modulo 2^WIDTH; carry/borrow is captured in flag_cy.
- Reset asserted mid-sequence clears state at the next edge, regardless of the pending op.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with ce_a = ce_cy = 1 and op = ADD -> acc_v = 0x00, z = 1, cy = s = o = 0.
- Source mux: mem_out = 0x11, immediate = 0x22, reg_out = 0x33; sweep data_src 0..3 -> alu_in = 0x11, 0x22, 0x11, 0x33. Then LD with data_src = 3 -> acc_v = 0x33.
- ADD/ADC:
  - acc = 0xFF, ADD imm 0x01 -> acc = 0x00, cy = 1, z = 1, s = 0, o = 0.
  - Then ADC imm 0x00 -> acc = 0x01, cy = 0, z = 0.
  - acc = 0x7F, ADD 0x01 -> acc = 0x80, s = 1, o = 1.
- SUB/SBC:
  - acc = 0x00, SUB 0x01 -> acc = 0xFF, cy = 1, s = 1.
  - Then SBC 0x00 -> acc = 0xFE, cy = 0.
  - acc = 0x80, SUB 0x01 -> acc = 0x7F, o = 1.
- Logic ops: acc = 0xF0, with operand 0x3C:
  - AND -> 0x30
  - OR -> 0xFC
  - XOR -> 0xCC
  - each with cy = 0 (ce_cy = 1), o = 0; AND 0x0F on acc 0xF0 -> z = 1.
- Enables:
  - ce_a = 0, ce_cy = 1, ADD causing carry -> acc and z/s/o unchanged, cy = 1.
  - ce_a = 1, ce_cy = 0 -> acc updates, cy holds.
